// File: rtl/uart_tx_dev_if.sv
// rtl/uart_tx_dev_if.sv - word-addressed register bus between the system bridge and the UART transmitter
interface uart_tx_dev_if;
   logic [29:0] Addr;
   logic        WE;
   logic [31:0] Din;
   logic [31:0] Dout;

   modport master (output Addr, output WE, output Din, input Dout);
   modport slave  (input Addr, input WE, input Din, output Dout);
endinterface

// File: rtl/uart_tx_dev.sv
// rtl/uart_tx_dev.sv - memory-mapped 8N1 UART transmitter with transmit FIFO and completion interrupt
module uart_tx_dev #(
   parameter int          DEPTH     = 4,
   parameter logic [15:0] DIV_RESET = 16'd434
) (
   input  logic          clk,
   input  logic          reset,
   uart_tx_dev_if.slave  bus,
   output logic          IRQ,
   output logic          tx
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t       state;
   logic         ctrl_en;
   logic         ctrl_ie;
   logic [15:0]  baud_div;
   logic         ovr;

   logic [7:0]   mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic [AW:0]  count;
   logic [3:0]   count4;
   logic         full;
   logic         empty;
   logic         busy;

   logic [7:0]   shift;
   logic [15:0]  frame_div;
   logic [15:0]  cyc_cnt;
   logic [3:0]   bit_cnt;

   logic [15:0]  div_eff;
   logic         bit_end;
   logic         pop;
   logic         push;
   logic         wr_ctrl;
   logic         wr_baud;
   logic         wr_data;
   logic         wr_status;
   logic         unused_bits;

   assign unused_bits = ^{bus.Addr[29:2], bus.Din[31:16]};

   assign wr_ctrl   = bus.WE && (bus.Addr[1:0] == 2'd0);
   assign wr_baud   = bus.WE && (bus.Addr[1:0] == 2'd1);
   assign wr_data   = bus.WE && (bus.Addr[1:0] == 2'd2);
   assign wr_status = bus.WE && (bus.Addr[1:0] == 2'd3);

   assign count  = wr_ptr - rd_ptr;
   assign count4 = 4'(count);
   assign full   = (count == (AW+1)'(DEPTH));
   assign empty  = (count == '0);
   assign busy   = (state != IDLE);

   // A divisor of zero would stall the bit timer, so it behaves as one
   assign div_eff = (baud_div == 16'd0) ? 16'd1 : baud_div;
   assign bit_end = (cyc_cnt == 16'd0);

   // A new frame is loaded from IDLE, or straight out of the last stop cycle so frames run back-to-back
   assign pop  = ctrl_en && !empty && ((state == IDLE) || ((state == STOP) && bit_end));
   // A simultaneous pop frees a slot, so a push into a full FIFO is still taken in that cycle
   assign push = wr_data && (!full || pop);

   // Control, divisor and sticky overrun registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_en  <= 1'b0;
         ctrl_ie  <= 1'b0;
         baud_div <= DIV_RESET;
         ovr      <= 1'b0;
      end else begin
         if (wr_ctrl) begin
            ctrl_en <= bus.Din[0];
            ctrl_ie <= bus.Din[1];
         end
         if (wr_baud) begin
            baud_div <= bus.Din[15:0];
         end
         if (wr_status) begin
            ovr <= 1'b0;
         end else if (wr_data && !push) begin
            ovr <= 1'b1;
         end
      end
   end

   // FIFO pointers; one extra bit distinguishes full from empty
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // FIFO storage; contents need no reset since the pointers mark them invalid
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= bus.Din[7:0];
      end
   end

   // Frame sequencer: start bit, eight data bits LSB first, stop bit, each held frame_div cycles
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         tx        <= 1'b1;
         shift     <= 8'd0;
         frame_div <= 16'd1;
         cyc_cnt   <= 16'd0;
         bit_cnt   <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               tx <= 1'b1;
               if (pop) begin
                  shift     <= mem[rd_ptr[AW-1:0]];
                  frame_div <= div_eff;
                  cyc_cnt   <= div_eff - 16'd1;
                  bit_cnt   <= 4'd0;
                  tx        <= 1'b0;
                  state     <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  tx      <= shift[0];
                  cyc_cnt <= frame_div - 16'd1;
                  state   <= DATA;
               end else begin
                  cyc_cnt <= cyc_cnt - 16'd1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  cyc_cnt <= frame_div - 16'd1;
                  if (bit_cnt == 4'd7) begin
                     bit_cnt <= 4'd8;
                     tx      <= 1'b1;
                     state   <= STOP;
                  end else begin
                     shift   <= shift >> 1;
                     tx      <= shift[1];
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end else begin
                  cyc_cnt <= cyc_cnt - 16'd1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  if (pop) begin
                     shift     <= mem[rd_ptr[AW-1:0]];
                     frame_div <= div_eff;
                     cyc_cnt   <= div_eff - 16'd1;
                     bit_cnt   <= 4'd0;
                     tx        <= 1'b0;
                     state     <= START;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  cyc_cnt <= cyc_cnt - 16'd1;
               end
            end
            default: begin
               state <= IDLE;
               tx    <= 1'b1;
            end
         endcase
      end
   end

   // Transmit-complete interrupt: enabled, nothing queued and the line is idle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         IRQ <= 1'b0;
      end else begin
         IRQ <= ctrl_ie && empty && !busy;
      end
   end

   // Register read mux
   always_comb begin
      bus.Dout = 32'd0;
      case (bus.Addr[1:0])
         2'd0:    bus.Dout = {30'd0, ctrl_ie, ctrl_en};
         2'd1:    bus.Dout = {16'd0, baud_div};
         2'd2:    bus.Dout = 32'd0;
         default: bus.Dout = {24'd0, count4, ovr, busy, empty, full};
      endcase
   end
endmodule

// File: tb/tb_uart_tx_dev.sv
// tb/tb_uart_tx_dev.sv - directed scoreboard bench for uart_tx_dev
module tb_uart_tx_dev;
   typedef struct {
      logic [7:0] data;
      int         div;
   } frame_t;

   logic clk;
   logic reset;
   logic irq;
   logic tx;

   int n_cmp;
   int n_err;
   int cyc;
   int frames_done;
   frame_t exp_q[$];
   int starts[$];

   uart_tx_dev_if bus();

   uart_tx_dev #(.DEPTH(4), .DIV_RESET(16'd434)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .IRQ   (irq),
      .tx    (tx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.Addr = {28'd0, a};
      bus.Din  = d;
      bus.WE   = 1'b1;
      @(negedge clk);
      bus.WE   = 1'b0;
   endtask

   task automatic rd_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
      @(negedge clk);
      bus.Addr = {28'd0, a};
      #1;
      check(tag, bus.Dout, exp);
   endtask

   task automatic push_exp(input logic [7:0] d, input int div);
      frame_t f;
      f.data = d;
      f.div  = div;
      exp_q.push_back(f);
   endtask

   task automatic wait_frames(input string tag, input int target, input int budget);
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         #1;
         if (frames_done >= target) break;
      end
      check(tag, frames_done, target);
   endtask

   // Serial monitor: checks every cycle of every frame against the scoreboard
   initial begin : monitor
      frame_t f;
      bit     ab;
      logic   b;
      frames_done = 0;
      forever begin
         @(negedge clk);
         if (!reset && tx === 1'b0) begin
            n_cmp++;
            assert (exp_q.size() != 0) else begin
               n_err++;
               $error("FAIL unexpected_frame: observed start bit at cycle %0d expected no frame", cyc);
            end
            if (exp_q.size() == 0) begin
               for (int k = 0; k < 200 && tx === 1'b0; k++) @(negedge clk);
            end else begin
               f = exp_q.pop_front();
               starts.push_back(cyc);
               ab = 1'b0;
               for (int i = 0; i < 10 && !ab; i++) begin
                  b = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : f.data[i-1];
                  for (int j = 0; j < f.div && !ab; j++) begin
                     if (i != 0 || j != 0) @(negedge clk);
                     if (reset) ab = 1'b1;
                     else check($sformatf("frame_%02h_bit%0d", f.data, i), {31'd0, tx}, {31'd0, b});
                  end
               end
               if (!ab) frames_done++;
            end
         end
      end
   end

   initial begin : stim
      int base;
      n_cmp    = 0;
      n_err    = 0;
      cyc      = 0;
      reset    = 1'b1;
      bus.Addr = 30'd0;
      bus.Din  = 32'd0;
      bus.WE   = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_tx", {31'd0, tx}, 32'd1);
      check("reset_irq", {31'd0, irq}, 32'd0);
      reset = 1'b0;

      rd_check("rst_ctrl", 2'd0, 32'd0);
      rd_check("rst_baud", 2'd1, 32'd434);
      rd_check("rst_data", 2'd2, 32'd0);
      rd_check("rst_status", 2'd3, 32'h02);

      // Single frame 0xA5 at DIV=4
      wr(2'd1, 32'd4);
      wr(2'd0, 32'd1);
      push_exp(8'hA5, 4);
      wr(2'd2, 32'hA5);
      check("lat_before", {31'd0, tx}, 32'd1);
      @(negedge clk);
      check("lat_fall", {31'd0, tx}, 32'd0);
      wait_frames("frame_a5_done", 1, 200);
      rd_check("a5_status_idle", 2'd3, 32'h02);

      // Interrupt on completion at DIV=2
      wr(2'd1, 32'd2);
      push_exp(8'h3C, 2);
      wr(2'd2, 32'h3C);
      wr(2'd0, 32'd3);
      base = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         #1;
         if (irq) base++;
         if (frames_done >= 2) break;
      end
      check("irq_frames", frames_done, 2);
      check("irq_low_in_frame", base, 0);
      @(negedge clk);
      check("irq_stop_edge", {31'd0, irq}, 32'd0);
      @(negedge clk);
      check("irq_rise", {31'd0, irq}, 32'd1);
      push_exp(8'h96, 2);
      wr(2'd2, 32'h96);
      check("irq_hold_write_edge", {31'd0, irq}, 32'd1);
      @(negedge clk);
      check("irq_drop", {31'd0, irq}, 32'd0);
      wait_frames("frame_96_done", 3, 200);

      // Overrun with EN=0, then back-to-back drain
      wr(2'd0, 32'd0);
      push_exp(8'h11, 2);
      push_exp(8'h22, 2);
      push_exp(8'h33, 2);
      push_exp(8'h44, 2);
      wr(2'd2, 32'h11);
      wr(2'd2, 32'h22);
      wr(2'd2, 32'h33);
      wr(2'd2, 32'h44);
      wr(2'd2, 32'h55);
      rd_check("ovr_status_full", 2'd3, 32'h49);
      wr(2'd3, 32'd0);
      rd_check("ovr_cleared", 2'd3, 32'h41);
      starts.delete();
      wr(2'd0, 32'd1);
      wait_frames("b2b4_done", 7, 400);
      check("b2b4_count", starts.size(), 4);
      for (int i = 0; i < 3 && i + 1 < starts.size(); i++)
         check($sformatf("b2b4_gap%0d", i), starts[i+1] - starts[i], 20);

      // Asynchronous reset in the middle of a DIV=3 frame
      wr(2'd1, 32'd3);
      push_exp(8'h00, 3);
      wr(2'd2, 32'h00);
      wr(2'd2, 32'h81);
      check("rst_mid_start", {31'd0, tx}, 32'd0);
      repeat (7) @(negedge clk);
      check("rst_mid_data_low", {31'd0, tx}, 32'd0);
      base = frames_done;
      #1;
      reset = 1'b1;
      #1;
      check("rst_async_tx", {31'd0, tx}, 32'd1);
      bus.Addr = 30'd3;
      #1;
      check("rst_async_status", bus.Dout, 32'h02);
      @(negedge clk);
      #1;
      reset = 1'b0;
      rd_check("rst_after_status", 2'd3, 32'h02);
      repeat (60) @(negedge clk);
      check("rst_no_frame", frames_done, base);
      check("rst_tx_idle", {31'd0, tx}, 32'd1);

      // BAUD change mid-frame takes effect on the next frame
      wr(2'd1, 32'd2);
      push_exp(8'hC3, 2);
      push_exp(8'h5A, 8);
      wr(2'd2, 32'hC3);
      wr(2'd2, 32'h5A);
      starts.delete();
      wr(2'd0, 32'd1);
      repeat (3) @(negedge clk);
      wr(2'd1, 32'd8);
      wait_frames("baud_done", base + 2, 400);
      check("baud_count", starts.size(), 2);
      if (starts.size() >= 2) check("baud_first_len", starts[1] - starts[0], 20);

      repeat (5) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      rd_check("final_status", 2'd3, 32'h02);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
